// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller:
// parameter defaults, address slicing and the controller state encoding.
package cache_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_INDEX_WIDTH = 6;
  localparam int DEF_TAG_WIDTH   = 8;
  localparam int DEF_NUM_WAYS    = 4;

  // One word per line, so the offset only selects a byte inside the word.
  localparam int OFFSET_WIDTH = 2;

  // Address layout: {tag, index, offset}.
  localparam int INDEX_LSB = OFFSET_WIDTH;
  localparam int TAG_LSB   = OFFSET_WIDTH + DEF_INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL_REQ,
    FILL_WAIT,
    ALLOC,
    RESP
  } state_t;

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement choice for a missing set: the lowest invalid way, otherwise
// the lowest way whose reference bit is clear, otherwise way 0.
module cache_victim_sel #(
  parameter int NUM_WAYS = cache_pkg::DEF_NUM_WAYS
) (
  input  logic [NUM_WAYS-1:0] r_valid,
  input  logic [NUM_WAYS-1:0] r_ref,
  output logic [NUM_WAYS-1:0] victim
);

  logic [NUM_WAYS-1:0] w_invalid;
  logic [NUM_WAYS-1:0] w_unref;
  logic [NUM_WAYS-1:0] w_pick_invalid;
  logic [NUM_WAYS-1:0] w_pick_unref;

  assign w_invalid = ~r_valid;
  assign w_unref   = ~r_ref;

  // x & -x isolates the lowest set bit, giving a one-hot pick.
  assign w_pick_invalid = w_invalid & (~w_invalid + NUM_WAYS'(1));
  assign w_pick_unref   = w_unref & (~w_unref + NUM_WAYS'(1));

  // Priority between the three fallbacks.
  always_comb begin
    if (|w_invalid) begin
      victim = w_pick_invalid;
    end else if (|w_unref) begin
      victim = w_pick_unref;
    end else begin
      victim = NUM_WAYS'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate cache controller with one word per line. The
// tag/data/state arrays live outside; this block reads the selected set
// combinationally through r_* and issues writes through wr_en/way_sel.
module cache_controller
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
  parameter int NUM_WAYS    = DEF_NUM_WAYS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req_valid,
  output logic                          cpu_req_ready,
  input  logic                          cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_req_wdata,
  output logic                          cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]         cpu_resp_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [DATA_WIDTH-1:0]         mem_req_wdata,
  input  logic                          mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_resp_rdata,
  output logic [INDEX_WIDTH-1:0]        index,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0] r_tags,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0] r_data,
  input  logic [NUM_WAYS-1:0]           r_valid,
  input  logic [NUM_WAYS-1:0]           r_dirty,
  input  logic [NUM_WAYS-1:0]           r_ref,
  output logic                          wr_en,
  output logic [NUM_WAYS-1:0]           way_sel,
  output logic [TAG_WIDTH-1:0]          w_tag,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic                          w_valid,
  output logic                          w_dirty,
  output logic                          update_ref,
  output logic [NUM_WAYS-1:0]           w_ref
);

  localparam int L_INDEX_LSB = OFFSET_WIDTH;
  localparam int L_TAG_LSB   = OFFSET_WIDTH + INDEX_WIDTH;

  state_t                  r_state;
  logic                    r_we;
  logic [TAG_WIDTH-1:0]    r_req_tag;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NUM_WAYS-1:0]     r_victim;
  logic [TAG_WIDTH-1:0]    r_vic_tag;
  logic [DATA_WIDTH-1:0]   r_vic_data;
  logic                    r_vic_dirty;
  logic [DATA_WIDTH-1:0]   r_fill_data;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [NUM_WAYS-1:0]     w_hit;
  logic [NUM_WAYS-1:0]     w_victim;
  logic [DATA_WIDTH-1:0]   w_hit_data;
  logic [DATA_WIDTH-1:0]   w_vic_data;
  logic [TAG_WIDTH-1:0]    w_vic_tag;
  logic                    w_vic_dirty;
  logic [NUM_WAYS-1:0]     w_ref_way;
  logic [NUM_WAYS-1:0]     w_ref_or;
  logic                    w_unused_offset;

  // Byte offset bits carry no meaning for a word-per-line cache.
  assign w_unused_offset = ^cpu_req_addr[OFFSET_WIDTH-1:0];

  // Per-way tag compare against the latched request.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
    assign w_hit[gi] = r_valid[gi] &&
                       (r_tags[gi*TAG_WIDTH +: TAG_WIDTH] == r_req_tag);
  end

  cache_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .r_valid (r_valid),
    .r_ref   (r_ref),
    .victim  (w_victim)
  );

  // One-hot muxes pulling the hit-way data and the victim line fields.
  always_comb begin
    w_hit_data  = '0;
    w_vic_data  = '0;
    w_vic_tag   = '0;
    w_vic_dirty = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (w_hit[i]) begin
        w_hit_data = w_hit_data | r_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_victim[i]) begin
        w_vic_data  = w_vic_data | r_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_vic_tag   = w_vic_tag | r_tags[i*TAG_WIDTH +: TAG_WIDTH];
        w_vic_dirty = w_vic_dirty | (r_valid[i] & r_dirty[i]);
      end
    end
  end

  // Controller state and latched request/victim/fill context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_req_tag   <= '0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_victim    <= '0;
      r_vic_tag   <= '0;
      r_vic_data  <= '0;
      r_vic_dirty <= 1'b0;
      r_fill_data <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_valid) begin
            r_we      <= cpu_req_we;
            r_req_tag <= cpu_req_addr[L_TAG_LSB +: TAG_WIDTH];
            r_index   <= cpu_req_addr[L_INDEX_LSB +: INDEX_WIDTH];
            r_wdata   <= cpu_req_wdata;
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (|w_hit) begin
            r_rdata <= r_we ? r_wdata : w_hit_data;
            r_state <= RESP;
          end else begin
            r_victim    <= w_victim;
            r_vic_tag   <= w_vic_tag;
            r_vic_data  <= w_vic_data;
            r_vic_dirty <= w_vic_dirty;
            if (w_vic_dirty) begin
              r_state <= WRITEBACK;
            end else if (r_we) begin
              r_state <= ALLOC;
            end else begin
              r_state <= FILL_REQ;
            end
          end
        end
        WRITEBACK: begin
          if (mem_req_ready) begin
            r_state <= r_we ? ALLOC : FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            r_state <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            r_fill_data <= mem_resp_rdata;
            r_state     <= ALLOC;
          end
        end
        ALLOC: begin
          r_rdata <= r_we ? r_wdata : r_fill_data;
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; only the LOOKUP hit strobes
  // depend on the live array read.
  always_comb begin
    cpu_req_ready  = (r_state == IDLE);
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    index          = r_index;
    wr_en          = 1'b0;
    way_sel        = '0;
    w_tag          = '0;
    w_data         = '0;
    w_valid        = 1'b0;
    w_dirty        = 1'b0;
    update_ref     = 1'b0;
    w_ref          = '0;
    w_ref_way      = (r_state == ALLOC) ? r_victim : w_hit;
    w_ref_or       = r_ref | w_ref_way;
    case (r_state)
      LOOKUP: begin
        if (|w_hit) begin
          update_ref = 1'b1;
          w_ref      = (&w_ref_or) ? w_ref_way : w_ref_or;
          if (r_we) begin
            wr_en   = 1'b1;
            way_sel = w_hit;
            w_tag   = r_req_tag;
            w_data  = r_wdata;
            w_valid = 1'b1;
            w_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {r_vic_tag, r_index, {OFFSET_WIDTH{1'b0}}};
        mem_req_wdata = r_vic_data;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_req_tag, r_index, {OFFSET_WIDTH{1'b0}}};
      end
      ALLOC: begin
        wr_en      = 1'b1;
        way_sel    = r_victim;
        w_tag      = r_req_tag;
        w_data     = r_we ? r_wdata : r_fill_data;
        w_valid    = 1'b1;
        w_dirty    = r_we;
        update_ref = 1'b1;
        w_ref      = (&w_ref_or) ? w_ref_way : w_ref_or;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = r_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus pushes expected CPU
// responses, memory requests, array writes and reference updates; a
// negedge monitor pops and compares them as the DUT produces them.
module tb_cache_controller;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 6;
  localparam int TW = 8;
  localparam int NW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [AW-1:0]     cpu_req_addr;
  logic [DW-1:0]     cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [DW-1:0]     cpu_resp_rdata;
  logic              mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_wdata;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_rdata;
  logic [IW-1:0]     index;
  logic [NW*TW-1:0]  r_tags;
  logic [NW*DW-1:0]  r_data;
  logic [NW-1:0]     r_valid, r_dirty, r_ref;
  logic              wr_en, w_valid, w_dirty, update_ref;
  logic [NW-1:0]     way_sel, w_ref;
  logic [TW-1:0]     w_tag;
  logic [DW-1:0]     w_data;

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .index          (index),
    .r_tags         (r_tags),
    .r_data         (r_data),
    .r_valid        (r_valid),
    .r_dirty        (r_dirty),
    .r_ref          (r_ref),
    .wr_en          (wr_en),
    .way_sel        (way_sel),
    .w_tag          (w_tag),
    .w_data         (w_data),
    .w_valid        (w_valid),
    .w_dirty        (w_dirty),
    .update_ref     (update_ref),
    .w_ref          (w_ref)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_lat;
    logic [31:0] cyc;
  } resp_t;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mreq_t;
  typedef struct packed {
    logic [5:0]  idx;
    logic [3:0]  way;
    logic [7:0]  tag;
    logic [31:0] data;
    logic        dirty;
  } awr_t;
  typedef struct packed {
    logic [5:0] idx;
    logic [3:0] bits;
  } ref_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  awr_t  awr_q[$];
  ref_t  ref_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input string got, input string want);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask

  // ---------------- external array model (combinational read) ----------
  logic [TW-1:0] m_tag   [0:63][0:NW-1];
  logic [DW-1:0] m_data  [0:63][0:NW-1];
  logic          m_valid [0:63][0:NW-1];
  logic          m_dirty [0:63][0:NW-1];
  logic [NW-1:0] m_ref   [0:63];
  logic          array_clear;

  always_comb begin
    r_tags  = '0;
    r_data  = '0;
    r_valid = '0;
    r_dirty = '0;
    for (int i = 0; i < NW; i++) begin
      r_tags[i*TW +: TW] = m_tag[index][i];
      r_data[i*DW +: DW] = m_data[index][i];
      r_valid[i]         = m_valid[index][i];
      r_dirty[i]         = m_dirty[index][i];
    end
    r_ref = m_ref[index];
  end

  always @(posedge clk) begin
    if (array_clear) begin
      for (int s = 0; s < 64; s++) begin
        m_ref[s] <= '0;
        for (int i = 0; i < NW; i++) begin
          m_tag[s][i]   <= '0;
          m_data[s][i]  <= '0;
          m_valid[s][i] <= 1'b0;
          m_dirty[s][i] <= 1'b0;
        end
      end
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NW; i++) begin
          if (way_sel[i]) begin
            m_tag[index][i]   <= w_tag;
            m_data[index][i]  <= w_data;
            m_valid[index][i] <= w_valid;
            m_dirty[index][i] <= w_dirty;
          end
        end
      end
      if (update_ref) m_ref[index] <= w_ref;
    end
  end

  // ---------------- memory responder ----------------------------------
  logic [31:0] mem [logic [15:0]];
  int          mem_delay = 0;
  bit          drop_resp = 1'b0;

  initial begin
    bit          pend;
    int          wcnt;
    logic [31:0] pdata;
    pend = 1'b0;
    wcnt = 0;
    pdata = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    mem[16'h1234] = 32'hDEADBEEF;
    mem[16'h2234] = 32'h22222222;
    mem[16'h3234] = 32'h33333333;
    mem[16'h4234] = 32'h44444444;
    mem[16'h5234] = 32'h55555555;
    mem[16'h0500] = 32'h05050505;
    mem[16'h0804] = 32'h00C0FFEE;
    forever begin
      @(posedge clk);
      #1;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
        wcnt = 0;
      end else if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pdata;
        pend = 1'b0;
      end else if (mem_req_valid) begin
        if (wcnt < mem_delay) begin
          wcnt++;
        end else begin
          wcnt = 0;
          mem_req_ready = 1'b1;
          if (mem_req_we) begin
            mem[mem_req_addr] = mem_req_wdata;
          end else begin
            pdata = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'hBAD00000;
            pend  = !drop_resp;
          end
        end
      end
    end
  end

  // ---------------- monitor -------------------------------------------
  initial begin
    resp_t       er;
    mreq_t       em;
    awr_t        ea;
    ref_t        ef;
    bit          p_stall;
    logic        p_we;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    p_stall = 1'b0;
    p_we = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_stall = 1'b0;
      end else begin
        if (cpu_resp_valid) begin
          if (resp_q.size() == 0) begin
            flag("cpu_resp", "unexpected response", "none");
          end else begin
            er = resp_q.pop_front();
            $display("resp rdata=%h cycle=%0d", cpu_resp_rdata, cyc);
            chk("resp_rdata", cpu_resp_rdata, er.rdata);
            if (er.chk_lat) chk("resp_cycle", 32'(cyc), er.cyc);
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          if (mreq_q.size() == 0) begin
            flag("mem_req", "unexpected request", "none");
          end else begin
            em = mreq_q.pop_front();
            chk("mem_req_we", 32'(mem_req_we), 32'(em.we));
            chk("mem_req_addr", 32'(mem_req_addr), 32'(em.addr));
            if (em.we) chk("mem_req_wdata", mem_req_wdata, em.wdata);
          end
        end
        if (wr_en) begin
          if (awr_q.size() == 0) begin
            flag("wr_en", "unexpected array write", "none");
          end else begin
            ea = awr_q.pop_front();
            chk("wr_index", 32'(index), 32'(ea.idx));
            chk("wr_way_sel", 32'(way_sel), 32'(ea.way));
            chk("wr_tag", 32'(w_tag), 32'(ea.tag));
            chk("wr_data", w_data, ea.data);
            chk("wr_valid", 32'(w_valid), 32'd1);
            chk("wr_dirty", 32'(w_dirty), 32'(ea.dirty));
          end
        end
        if (update_ref) begin
          if (ref_q.size() == 0) begin
            flag("update_ref", "unexpected ref update", "none");
          end else begin
            ef = ref_q.pop_front();
            chk("ref_index", 32'(index), 32'(ef.idx));
            chk("w_ref", 32'(w_ref), 32'(ef.bits));
          end
        end
        if (p_stall) begin
          chk("stall_valid", 32'(mem_req_valid), 32'd1);
          chk("stall_we", 32'(mem_req_we), 32'(p_we));
          chk("stall_addr", 32'(mem_req_addr), 32'(p_addr));
          chk("stall_wdata", mem_req_wdata, p_wdata);
        end
        p_stall = mem_req_valid && !mem_req_ready;
        p_we    = mem_req_we;
        p_addr  = mem_req_addr;
        p_wdata = mem_req_wdata;
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------
  task automatic exp_mem(input logic we, input logic [15:0] a, input logic [31:0] d);
    mreq_q.push_back('{we: we, addr: a, wdata: d});
  endtask

  task automatic exp_wr(input logic [5:0] idx, input logic [3:0] way,
                        input logic [7:0] tag, input logic [31:0] d, input logic dirty);
    awr_q.push_back('{idx: idx, way: way, tag: tag, data: d, dirty: dirty});
  endtask

  task automatic exp_ref(input logic [5:0] idx, input logic [3:0] bits);
    ref_q.push_back('{idx: idx, bits: bits});
  endtask

  task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                       output int acc, output bit ok);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    ok  = 1'b0;
    acc = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    if (!ok) flag("cpu_req_ready", "never ready", "accept");
  endtask

  // lat < 0 skips the latency comparison for that response.
  task automatic req(input logic we, input logic [15:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input int lat);
    int acc;
    bit ok;
    issue(we, a, d, acc, ok);
    if (ok) resp_q.push_back('{rdata: exp, chk_lat: (lat >= 0), cyc: 32'(acc + lat)});
    for (int k = 0; k < 200 && resp_q.size() != 0; k++) @(posedge clk);
    if (resp_q.size() != 0) begin
      flag("cpu_resp", "timeout", "response");
      resp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ---------------------------------
  initial begin
    int  acc;
    bit  ok;
    rst           = 1'b1;
    array_clear   = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    #2;
    chk("rst_req_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_update_ref", 32'(update_ref), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    array_clear = 1'b0;

    // Cold read: fill from memory into way 0 of set 0x0D.
    exp_mem(1'b0, 16'h1234, 32'h0);
    exp_wr(6'h0D, 4'b0001, 8'h12, 32'hDEADBEEF, 1'b0);
    exp_ref(6'h0D, 4'b0001);
    req(1'b0, 16'h1234, 32'h0, 32'hDEADBEEF, 5);

    // Read hit.
    exp_ref(6'h0D, 4'b0001);
    req(1'b0, 16'h1234, 32'h0, 32'hDEADBEEF, 2);

    // Write hit makes way 0 dirty.
    exp_wr(6'h0D, 4'b0001, 8'h12, 32'hCAFEF00D, 1'b1);
    exp_ref(6'h0D, 4'b0001);
    req(1'b1, 16'h1234, 32'hCAFEF00D, 32'hCAFEF00D, 2);

    // Fill the remaining ways; the fourth saturates the reference bits.
    exp_mem(1'b0, 16'h2234, 32'h0);
    exp_wr(6'h0D, 4'b0010, 8'h22, 32'h22222222, 1'b0);
    exp_ref(6'h0D, 4'b0011);
    req(1'b0, 16'h2234, 32'h0, 32'h22222222, 5);
    exp_mem(1'b0, 16'h3234, 32'h0);
    exp_wr(6'h0D, 4'b0100, 8'h32, 32'h33333333, 1'b0);
    exp_ref(6'h0D, 4'b0111);
    req(1'b0, 16'h3234, 32'h0, 32'h33333333, 5);
    exp_mem(1'b0, 16'h4234, 32'h0);
    exp_wr(6'h0D, 4'b1000, 8'h42, 32'h44444444, 1'b0);
    exp_ref(6'h0D, 4'b1000);
    req(1'b0, 16'h4234, 32'h0, 32'h44444444, 5);

    // Full set: way 0 has ref 0 and is dirty -> writeback then fill.
    exp_mem(1'b1, 16'h1234, 32'hCAFEF00D);
    exp_mem(1'b0, 16'h5234, 32'h0);
    exp_wr(6'h0D, 4'b0001, 8'h52, 32'h55555555, 1'b0);
    exp_ref(6'h0D, 4'b1001);
    req(1'b0, 16'h5234, 32'h0, 32'h55555555, 6);

    // Hit on way 2 after replacement.
    exp_ref(6'h0D, 4'b1101);
    req(1'b0, 16'h3234, 32'h0, 32'h33333333, 2);

    // Clean write misses into set 0: no memory traffic.
    exp_wr(6'h00, 4'b0001, 8'h01, 32'h00000011, 1'b1);
    exp_ref(6'h00, 4'b0001);
    req(1'b1, 16'h0100, 32'h00000011, 32'h00000011, 3);
    exp_wr(6'h00, 4'b0010, 8'h02, 32'h00000022, 1'b1);
    exp_ref(6'h00, 4'b0011);
    req(1'b1, 16'h0200, 32'h00000022, 32'h00000022, 3);
    exp_wr(6'h00, 4'b0100, 8'h03, 32'h00000033, 1'b1);
    exp_ref(6'h00, 4'b0111);
    req(1'b1, 16'h0300, 32'h00000033, 32'h00000033, 3);
    exp_wr(6'h00, 4'b1000, 8'h04, 32'h00000044, 1'b1);
    exp_ref(6'h00, 4'b1000);
    req(1'b1, 16'h0400, 32'h00000044, 32'h00000044, 3);

    // Slow memory: writeback of way 0 held for 10 stalled cycles.
    mem_delay = 10;
    exp_mem(1'b1, 16'h0100, 32'h00000011);
    exp_mem(1'b0, 16'h0500, 32'h0);
    exp_wr(6'h00, 4'b0001, 8'h05, 32'h05050505, 1'b0);
    exp_ref(6'h00, 4'b1001);
    req(1'b0, 16'h0500, 32'h0, 32'h05050505, -1);
    mem_delay = 0;

    // Write miss with dirty victim (way 1): writeback, then allocate.
    exp_mem(1'b1, 16'h0200, 32'h00000022);
    exp_wr(6'h00, 4'b0010, 8'h06, 32'h00000066, 1'b1);
    exp_ref(6'h00, 4'b1011);
    req(1'b1, 16'h0600, 32'h00000066, 32'h00000066, 4);

    // Reset while waiting for fill data.
    drop_resp = 1'b1;
    exp_mem(1'b0, 16'h0804, 32'h0);
    issue(1'b0, 16'h0804, 32'h0, acc, ok);
    for (int k = 0; k < 20 && cyc < acc + 4; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_req_ready", 32'(cpu_req_ready), 32'd1);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("midrst_index", 32'(index), 32'd0);
    chk("midrst_fill_seen", 32'(mreq_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drop_resp = 1'b0;

    // Same request completes normally afterwards.
    exp_mem(1'b0, 16'h0804, 32'h0);
    exp_wr(6'h01, 4'b0001, 8'h08, 32'h00C0FFEE, 1'b0);
    exp_ref(6'h01, 4'b0001);
    req(1'b0, 16'h0804, 32'h0, 32'h00C0FFEE, 5);

    repeat (5) @(posedge clk);
    chk("left_resp", 32'(resp_q.size()), 32'd0);
    chk("left_mem", 32'(mreq_q.size()), 32'd0);
    chk("left_wr", 32'(awr_q.size()), 32'd0);
    chk("left_ref", 32'(ref_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 DATA_WIDTH, 32, word width.
REQ-002 ADDR_WIDTH, 16, byte address width.
REQ-003 INDEX_WIDTH, 6, set index width.
REQ-004 TAG_WIDTH, 8, tag width. TAG_WIDTH+INDEX_WIDTH+2 SHALL equal ADDR_WIDTH.
REQ-005 NUM_WAYS, 4, associativity.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 cpu_req_valid  in  1  CPU request present.
REQ-009 cpu_req_ready  out  1  controller accepts request.
REQ-010 cpu_req_we  in  1  1=write, 0=read.
REQ-011 cpu_req_addr  in  ADDR_WIDTH  byte address. Tag=[15:8], index=[7:2], [1:0] ignored.
REQ-012 cpu_req_wdata  in  DATA_WIDTH  write word.
REQ-013 cpu_resp_valid  out  1  one-cycle completion pulse.
REQ-014 cpu_resp_rdata  out  DATA_WIDTH  response data.
REQ-015 mem_req_valid  out  1  memory request.
REQ-016 mem_req_ready  in  1  memory accepts request.
REQ-017 mem_req_we  out  1  1=writeback, 0=fill read.
REQ-018 mem_req_addr  out  ADDR_WIDTH  line address, [1:0]=0.
REQ-019 mem_req_wdata  out  DATA_WIDTH  writeback data.
REQ-020 mem_resp_valid / mem_resp_rdata  in  1 / DATA_WIDTH  fill data return.
REQ-021 index  out  INDEX_WIDTH  array set select.
REQ-022 r_tags, r_data, r_valid, r_dirty, r_ref  in  NUM_WAYS×field  packed per-way array read, way i at slice i.
REQ-023 wr_en, way_sel  out  1, NUM_WAYS  array write strobe, one-hot way.
REQ-024 w_tag, w_data, w_valid, w_dirty  out  TAG_WIDTH, DATA_WIDTH, 1, 1  array write fields.
REQ-025 update_ref, w_ref  out  1, NUM_WAYS  reference-bit write for the set.

Function
REQ-026 FSM states: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, ALLOC, RESP. Write-back, write-allocate, one word per line.
REQ-027 cpu_req_ready=1 only in IDLE. valid&ready latches we/addr/wdata -> LOOKUP. index = latched index in all states.
REQ-028 LOOKUP: hit = r_valid[i] & tag match, at most one way. Read hit -> RESP, rdata=hit-way data.
REQ-029 Write hit in LOOKUP: wr_en=1, way_sel=hit way, w_tag=req tag, w_data=wdata, w_valid=1, w_dirty=1, same cycle -> RESP.
REQ-030 Miss victim: lowest invalid way, else lowest way with r_ref=0, else way 0. Victim way/tag/data/dirty latched in LOOKUP.
REQ-031 Miss routing: dirty victim -> WRITEBACK. Clean write -> ALLOC (no fill). Clean read -> FILL_REQ.
REQ-032 WRITEBACK: mem_req_valid=1, we=1, addr={victim tag,index,00}, wdata=victim data, all held stable until mem_req_ready. Then -> ALLOC (write) or FILL_REQ (read). No response expected.
REQ-033 FILL_REQ: mem_req_valid=1, we=0, addr={req tag,index,00}, held until mem_req_ready -> FILL_WAIT.
REQ-034 FILL_WAIT: mem_resp_valid captures rdata -> ALLOC. mem_resp_valid in any other state is ignored.
REQ-035 ALLOC: wr_en=1, way_sel=victim, w_tag=req tag, w_valid=1, w_dirty=we, w_data = wdata (write) or fill data (read) -> RESP.
REQ-036 Reference update on LOOKUP hit and in ALLOC only: update_ref=1, w_ref=r_ref|onehot(way). If the result is all ones, w_ref=onehot(way).
REQ-037 RESP: cpu_resp_valid=1 for exactly one cycle, no backpressure -> IDLE. rdata = read data; for writes, rdata = wdata.
REQ-038 Latency from accept cycle T: hit resp T+2; clean write miss T+3; clean read miss with ready at T+2 and resp at T+3 gives resp T+5.
REQ-039 wr_en, update_ref, mem_req_valid and cpu_resp_valid SHALL be 0 outside the cases stated above.

Reset
REQ-040 rst asynchronously forces IDLE, clears latched registers and index to 0, and drives all outputs to 0 except cpu_req_ready=1.
REQ-041 rst mid-operation abandons any memory transaction. No array write is issued and no response is given.

Structure
REQ-042 cache_pkg holds the parameter defaults, OFFSET_WIDTH=2, the FSM state enum, and the tag/index slice widths.
REQ-043 One combinational sub-module, cache_victim_sel: inputs r_valid and r_ref, output one-hot victim.

Verification
REQ-044 Cold read 0x1234, memory ready immediately, resp 0xDEADBEEF one cycle later -> fill addr 0x1234; ALLOC way0 tag 0x12 index 0x0D dirty=0; resp 0xDEADBEEF at T+5.
REQ-045 Re-read 0x1234 -> hit, resp at T+2, no mem_req_valid, w_ref=0001.
REQ-046 Write 0x1234=0xCAFEF00D (hit, dirty), then reads of 0x2234/0x3234/0x4234 -> w_ref 0011, 0111, then 1000. Read 0x5234 -> writeback addr 0x1234 data 0xCAFEF00D, then fill 0x5234 into way0.
REQ-047 Write 0x0100=0x11 to an empty set -> no memory traffic, ALLOC way0 dirty=1, resp at T+3.
REQ-048 mem_req_ready low for 10 cycles in WRITEBACK -> mem_req_addr and mem_req_wdata stable on every cycle.
REQ-049 rst pulse in FILL_WAIT -> mem_req_valid=0, cpu_req_ready=1, no wr_en. The next request completes normally.
